// File: rtl/adc_sample_capture_pkg.sv
// adc_sample_capture_pkg: shared FSM states, RAM word layout and default sizing.
package adc_sample_capture_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_CAPTURE, ST_DONE} state_e;

    localparam int WORD_W  = 16;
    localparam int DATA_W  = 12;
    localparam int OTR_BIT = 15;
    localparam int PAD_HI  = 14;
    localparam int PAD_LO  = 12;
    localparam int DATA_HI = 11;
    localparam int DATA_LO = 0;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_PIPE_DELAY = 7;

    function automatic logic [WORD_W-1:0] pack_word(input logic otr, input logic [DATA_W-1:0] data);
        logic [WORD_W-1:0] w;
        w                  = '0;
        w[OTR_BIT]         = otr;
        w[PAD_HI:PAD_LO]   = '0;
        w[DATA_HI:DATA_LO] = data;
        return w;
    endfunction

endpackage

// File: rtl/adc_sample_capture_clk_divider.sv
// adc_clk_divider: divides CLK by 2*D to make ADC_CLK and flags every falling toggle
// with a registered one-cycle sample_event_o (one cycle after the falling edge).
module adc_clk_divider #(
    parameter int DIV_WIDTH = 11
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 load_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 adc_clk_o,
    output logic                 sample_event_o
);

    logic [DIV_WIDTH-1:0] d_q, d_d, cnt_q, cnt_d;
    logic                 clk_q, clk_d, ev_q, ev_d, wrap;

    always_comb begin
        wrap  = cnt_q == d_q - DIV_WIDTH'(1);
        d_d   = load_i ? ((div_i == '0) ? DIV_WIDTH'(1) : div_i) : d_q;
        cnt_d = (en_i && !wrap) ? cnt_q + DIV_WIDTH'(1) : '0;
        clk_d = en_i & (clk_q ^ wrap);
        ev_d  = en_i & wrap & clk_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            d_q   <= DIV_WIDTH'(1);
            cnt_q <= '0;
            clk_q <= 1'b0;
            ev_q  <= 1'b0;
        end else begin
            d_q   <= d_d;
            cnt_q <= cnt_d;
            clk_q <= clk_d;
            ev_q  <= ev_d;
        end
    end

    assign adc_clk_o      = clk_q;
    assign sample_event_o = ev_q;

endmodule

// File: rtl/adc_sample_capture.sv
// adc_sample_capture: clocks a parallel ADC, drops its pipeline latency and stores
// one block of {otr, pad, data} words in a simple dual-port RAM with registered read.
module adc_sample_capture
    import adc_sample_capture_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DIV_WIDTH  = 11,
    parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START_TURN,
    input  logic [DIV_WIDTH-1:0]  DIVIDER,
    input  logic [DATA_W-1:0]     ADC_BIT,
    input  logic                  ADC_OTR,
    output logic                  ADC_CLK,
    output logic                  ADC_OE,
    input  logic [ADDR_WIDTH-1:0] RAM_RD_ADDR,
    output logic [WORD_W-1:0]     RAM_DATA_OUT,
    output logic                  TURN_DONE,
    output logic                  BUSY,
    output logic                  OTR_SEEN
);

    localparam int N  = 2 ** ADDR_WIDTH;
    localparam int FW = $clog2(PIPE_DELAY + 1);

    state_e                state_q, state_d;
    logic [FW-1:0]         flush_q, flush_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  otr_seen_q, otr_seen_d, done_q, done_d, busy_q, busy_d;
    logic [DATA_W-1:0]     bit_q;
    logic                  otr_q, start, run, div_en, sample_event, we;
    logic [WORD_W-1:0]     mem [N];
    logic [WORD_W-1:0]     rd_q;

    assign start = START_TURN && !busy_q;
    assign run   = (state_q == ST_FLUSH) || (state_q == ST_CAPTURE);
    // Stop the divider on the edge that leaves CAPTURE so ADC_CLK stays glitch-free.
    assign div_en = run && (state_d != ST_DONE);

    adc_clk_divider #(.DIV_WIDTH(DIV_WIDTH)) u_div (
        .CLK            (CLK),
        .RST            (RST),
        .load_i         (start),
        .en_i           (div_en),
        .div_i          (DIVIDER),
        .adc_clk_o      (ADC_CLK),
        .sample_event_o (sample_event)
    );

    always_comb begin
        state_d    = state_q;
        flush_d    = flush_q;
        wr_addr_d  = wr_addr_q;
        otr_seen_d = otr_seen_q;
        we         = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d    = ST_FLUSH;
                flush_d    = '0;
                wr_addr_d  = '0;
                otr_seen_d = 1'b0;
            end
            ST_FLUSH: if (sample_event) begin
                flush_d = flush_q + FW'(1);
                if (flush_q == FW'(PIPE_DELAY - 1)) begin
                    state_d   = ST_CAPTURE;
                    wr_addr_d = '0;
                end
            end
            ST_CAPTURE: if (sample_event) begin
                we         = 1'b1;
                wr_addr_d  = wr_addr_q + ADDR_WIDTH'(1);
                otr_seen_d = otr_seen_q | otr_q;
                if (wr_addr_q == '1) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
        endcase
        done_d = state_q == ST_DONE;
        busy_d = start ? 1'b1 : (done_q ? 1'b0 : busy_q);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            flush_q    <= '0;
            wr_addr_q  <= '0;
            otr_seen_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            bit_q      <= '0;
            otr_q      <= 1'b0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            flush_q    <= flush_d;
            wr_addr_q  <= wr_addr_d;
            otr_seen_q <= otr_seen_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            bit_q      <= ADC_BIT;
            otr_q      <= ADC_OTR;
            rd_q       <= mem[RAM_RD_ADDR];
        end
    end

    always_ff @(posedge CLK) begin
        if (we) mem[wr_addr_q] <= pack_word(otr_q, bit_q);
    end

    assign ADC_OE       = !run;
    assign RAM_DATA_OUT = rd_q;
    assign TURN_DONE    = done_q;
    assign BUSY         = busy_q;
    assign OTR_SEEN     = otr_seen_q;

endmodule
